// File: rtl/image_stream_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : image_stream_ctrl                                       |
// | Description : Streams one frame from a pixel buffer through an image  |
// |               processor and out to a UART, one pixel at a time, high  |
// |               byte first.                                             |
// |               Optional macro STREAM_HEADER_EN prefixes each frame     |
// |               with the two header bytes 0xAA, 0x55.                   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module image_stream_ctrl #(
   parameter int NUM_PIXELS = 16384,
   parameter int ADDR_W     = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [15:0]       mem_rdata,
   output logic              proc_valid,
   output logic [15:0]       proc_data,
   input  logic              proc_res_valid,
   input  logic [15:0]       proc_res,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy
);

   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_PIXELS - 1);
`ifdef STREAM_HEADER_EN
   localparam logic [7:0]        c_hdr0      = 8'hAA;
   localparam logic [7:0]        c_hdr1      = 8'h55;
`endif

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      RD         = 4'd1,
      RD_WAIT    = 4'd2,
      PROC       = 4'd3,
      PROC_WAIT  = 4'd4,
      TX_HI      = 4'd5,
      TX_HI_WAIT = 4'd6,
      TX_LO      = 4'd7,
      TX_LO_WAIT = 4'd8,
      NEXT       = 4'd9
`ifdef STREAM_HEADER_EN
      ,
      HDR0       = 4'd10,
      HDR0_WAIT  = 4'd11,
      HDR1       = 4'd12,
      HDR1_WAIT  = 4'd13
`endif
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_send;       // a byte is handed to the UART this cycle
   logic              w_wait_done;  // a byte wait state is finishing this cycle
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_pixel;
   logic [7:0]        r_res_lo;
   logic [7:0]        r_tx_data;
   logic              r_tx_start;

   // r_tx_start is high exactly on the first cycle of a byte wait state,
   // which is the cycle on which tx_busy is not yet trustworthy.
   assign busy       = (r_state != IDLE);
   assign done       = (r_state == NEXT) && (r_addr == c_last_addr);
   assign mem_addr   = r_addr;
   assign mem_rd_en  = (r_state == RD);
   assign proc_valid = (r_state == PROC);
   assign proc_data  = r_pixel;
   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;

   // Next-state decode plus byte handshake qualifiers
   always_comb begin
      w_next      = r_state;
      w_send      = 1'b0;
      w_wait_done = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
`ifdef STREAM_HEADER_EN
               w_next = HDR0;
`else
               w_next = RD;
`endif
            end
         end
         RD:        w_next = RD_WAIT;
         RD_WAIT:   w_next = PROC;
         PROC:      w_next = PROC_WAIT;
         PROC_WAIT: if (proc_res_valid) w_next = TX_HI;
         TX_HI: begin
            w_send = !tx_busy;
            if (!tx_busy) w_next = TX_HI_WAIT;
         end
         TX_HI_WAIT: begin
            w_wait_done = !r_tx_start && !tx_busy;
            if (w_wait_done) w_next = TX_LO;
         end
         TX_LO: begin
            w_send = !tx_busy;
            if (!tx_busy) w_next = TX_LO_WAIT;
         end
         TX_LO_WAIT: begin
            w_wait_done = !r_tx_start && !tx_busy;
            if (w_wait_done) w_next = NEXT;
         end
         NEXT:      w_next = (r_addr == c_last_addr) ? IDLE : RD;
`ifdef STREAM_HEADER_EN
         HDR0: begin
            w_send = !tx_busy;
            if (!tx_busy) w_next = HDR0_WAIT;
         end
         HDR0_WAIT: begin
            w_wait_done = !r_tx_start && !tx_busy;
            if (w_wait_done) w_next = HDR1;
         end
         HDR1: begin
            w_send = !tx_busy;
            if (!tx_busy) w_next = HDR1_WAIT;
         end
         HDR1_WAIT: begin
            w_wait_done = !r_tx_start && !tx_busy;
            if (w_wait_done) w_next = RD;
         end
`endif
         default:   w_next = IDLE;
      endcase
   end

   // State register and the one-cycle UART send strobe
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tx_start <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_tx_start <= w_send;
      end
   end

   // Datapath: address counter, pixel/result latches and the held UART byte
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_pixel   <= '0;
         r_res_lo  <= '0;
         r_tx_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr <= '0;
`ifdef STREAM_HEADER_EN
                  r_tx_data <= c_hdr0;
`endif
               end
            end
            RD_WAIT:   r_pixel <= mem_rdata;
            PROC_WAIT: begin
               if (proc_res_valid) begin
                  // The byte is loaded before TX_HI so it is already stable
                  // on the cycle tx_start rises.
                  r_res_lo  <= proc_res[7:0];
                  r_tx_data <= proc_res[15:8];
               end
            end
            TX_HI_WAIT: if (w_wait_done) r_tx_data <= r_res_lo;
            NEXT: begin
               if (r_addr == c_last_addr) r_addr <= '0;
               else                       r_addr <= r_addr + ADDR_W'(1);
            end
`ifdef STREAM_HEADER_EN
            HDR0_WAIT: if (w_wait_done) r_tx_data <= c_hdr1;
`endif
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/image_stream_ctrl.md
IMAGE_STREAM_CTRL -- requirements
Module: image_stream_ctrl

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 16384, pixels per frame (128x128 RGB565).
REQ-002 SHALL have parameter ADDR_W, default 14, pixel buffer address width.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle frame start request.
REQ-006 SHALL have port busy  output  1  high while a frame is in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the last byte of a frame is accepted by the UART.
REQ-008 SHALL have port mem_addr  output  ADDR_W  pixel buffer read address.
REQ-009 SHALL have port mem_rd_en  output  1  buffer read strobe; mem_rdata is valid exactly one cycle later.
REQ-010 SHALL have port mem_rdata  input  16  buffer read data.
REQ-011 SHALL have port proc_valid  output  1  one-cycle pixel strobe to the image processor.
REQ-012 SHALL have port proc_data  output  16  pixel presented to the image processor.
REQ-013 SHALL have port proc_res_valid  input  1  image processor result strobe.
REQ-014 SHALL have port proc_res  input  16  processed pixel.
REQ-015 SHALL have port tx_data  output  8  byte to UART transmitter.
REQ-016 SHALL have port tx_start  output  1  one-cycle byte send strobe.
REQ-017 SHALL have port tx_busy  input  1  UART transmitter busy.

Function
REQ-018 SHALL implement states IDLE, RD, RD_WAIT, PROC, PROC_WAIT, TX_HI, TX_HI_WAIT, TX_LO, TX_LO_WAIT, NEXT.
REQ-019 IDLE: start=1 -> RD, address counter cleared to 0, busy=1 from the next cycle; start while busy SHALL be ignored.
REQ-020 RD: mem_rd_en=1 for one cycle with mem_addr=counter -> RD_WAIT; RD_WAIT: latch mem_rdata -> PROC.
REQ-021 PROC: proc_valid=1 for exactly one cycle with latched pixel on proc_data -> PROC_WAIT.
REQ-022 PROC_WAIT: hold until proc_res_valid=1, latch proc_res -> TX_HI; proc_res_valid in any other state SHALL be ignored.
REQ-023 TX_HI: when tx_busy=0, tx_start=1 one cycle with tx_data=result[15:8] -> TX_HI_WAIT; otherwise hold.
REQ-024 TX_HI_WAIT: ignore tx_busy on its first cycle, then hold until tx_busy=0 -> TX_LO.
REQ-025 TX_LO / TX_LO_WAIT: identical to REQ-023/024 with tx_data=result[7:0] -> NEXT.
REQ-026 NEXT: if counter==NUM_PIXELS-1, pulse done, clear busy, counter to 0 -> IDLE; else counter+1 -> RD.
REQ-027 Counter SHALL be ADDR_W bits and never exceed NUM_PIXELS-1; no wrap beyond the frame.
REQ-028 tx_data SHALL be held stable from tx_start until the matching wait state exits.
REQ-029 Each pixel SHALL be transmitted high byte first; bytes per frame = 2*NUM_PIXELS.
REQ-030 start coinciding with done SHALL be ignored; a new frame requires start in IDLE.

Reset
REQ-031 rst_n=0 on a rising edge SHALL force IDLE, counter=0, busy=0, done=0, mem_rd_en=0, proc_valid=0, tx_start=0, mem_addr=0, proc_data=0, tx_data=0.
REQ-032 Reset mid-frame SHALL abort immediately; no partial byte or done pulse after reset.

Configuration
REQ-033 Macro STREAM_HEADER_EN defined: after start, before the first RD, SHALL send header bytes 0xAA then 0x55 using REQ-023/024 handshake (states HDR0, HDR1 and their waits).
REQ-034 Macro STREAM_HEADER_EN undefined: no header states; IDLE goes directly to RD; byte count exactly 2*NUM_PIXELS.

Verification
REQ-035 NUM_PIXELS=4, buffer 0x1234,0xABCD,0x0000,0xFFFF, processor echoes with 1-cycle latency, tx_busy 10 cycles per byte -> bytes 12 34 AB CD 00 00 FF FF, one done pulse, busy low after.
REQ-036 Processor result delayed 20 cycles -> no tx_start until proc_res_valid; proc_valid pulses exactly once per pixel.
REQ-037 tx_busy held high 50 cycles at TX_HI -> tx_start stays 0 until tx_busy=0, then one pulse, data unchanged.
REQ-038 start pulsed mid-frame and on done cycle -> no restart, total bytes still 8 (10 with STREAM_HEADER_EN, first two AA 55).
REQ-039 rst_n=0 during TX_LO_WAIT of pixel 2 -> all outputs 0 next cycle, no done; new start restarts at mem_addr 0.
REQ-040 Default NUM_PIXELS=16384 -> mem_addr sequence 0..16383 with no repeats, final done after 32768 bytes.
